// File: rtl/cen_generator.sv
// -----------------------------------------------------------------------------
// cen_generator
//
// Turns the divided clock clk_slow (nominally a 50-cycle period in the
// clk_100mhz domain) into single-cycle clock-enable pulses on clk_100mhz. The
// block also measures each incoming period, reports when the period has been
// stable for a while (locked), and emits a further-divided enable (cen_div)
// for the FM sample pipeline.
//
// Optional feature macro: CEN_GEN_PERIOD_OUT_EN
//   When defined, an extra output 'period' carries the last measured period.
//   When undefined, the port is absent and the rest of the block is unchanged.
//
// Ports
//   clk_100mhz  in   1      system clock, the only clock in the block
//   reset       in   1      asynchronous, active-high reset
//   clk_slow    in   1      divided clock, sampled asynchronously
//   cen         out  1      one-cycle pulse per detected rising edge of clk_slow
//   cen_div     out  1      one-cycle pulse on every DIV-th cen while locked
//   locked      out  1      high while the period stays inside the window
//   lost        out  1      one-cycle pulse when leaving the locked state
//   period      out  PW     last measured period (CEN_GEN_PERIOD_OUT_EN only)
// -----------------------------------------------------------------------------
module cen_generator #(
    parameter int PERIOD_NOM = 50,
    parameter int PERIOD_TOL = 2,
    parameter int LOCK_EDGES = 4,
    parameter int TIMEOUT    = 200,
    parameter int DIV        = 6,
    parameter int PW         = 8
) (
    input  logic          clk_100mhz,
    input  logic          reset,
    input  logic          clk_slow,
    output logic          cen,
    output logic          cen_div,
    output logic          locked,
    output logic          lost
`ifdef CEN_GEN_PERIOD_OUT_EN
    ,
    output logic [PW-1:0] period
`endif
);

    localparam logic [PW-1:0] WIN_LO   = PW'(PERIOD_NOM - PERIOD_TOL);
    localparam logic [PW-1:0] WIN_HI   = PW'(PERIOD_NOM + PERIOD_TOL);
    localparam logic [PW-1:0] TO_LAST  = PW'(TIMEOUT - 1);
    localparam logic [PW-1:0] CNT_MAX  = {PW{1'b1}};
    localparam int            GW       = $clog2(LOCK_EDGES + 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_EDGES - 1);
    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Synchroniser chain plus one extra stage for edge detection
    logic          r_s0;
    logic          r_s1;
    logic          r_s2;

    logic [PW-1:0] r_cnt;
    logic [GW-1:0] r_good;
    logic [DW-1:0] r_div;
    state_t        r_state;

    logic          r_cen;
    logic          r_cen_div;
    logic          r_locked;
    logic          r_lost;

    logic          w_edge;
    logic [PW-1:0] w_cnt_inc;
    logic          w_in_win;
    logic          w_timeout;

    // Edge detect, saturating counter increment, window and timeout decode
    always_comb begin
        w_edge = r_s1 & ~r_s2;
        if (r_cnt == CNT_MAX) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + PW'(1);
        end
        // The saturated increment is also the measured period on an edge.
        w_in_win  = (w_cnt_inc >= WIN_LO) && (w_cnt_inc <= WIN_HI);
        // The counter is about to reach TIMEOUT; a simultaneous edge wins.
        w_timeout = ~w_edge && (r_cnt == TO_LAST);
    end

    // Two-flop synchroniser and the delayed copy used for edge detection
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_s0 <= 1'b0;
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s0 <= clk_slow;
            r_s1 <= r_s0;
            r_s2 <= r_s1;
        end
    end

    // Period counter, lock FSM and all registered pulse outputs
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_cnt     <= {PW{1'b0}};
            r_good    <= {GW{1'b0}};
            r_div     <= {DW{1'b0}};
            r_state   <= ST_UNLOCKED;
            r_cen     <= 1'b0;
            r_cen_div <= 1'b0;
            r_locked  <= 1'b0;
            r_lost    <= 1'b0;
        end else begin
            r_cen     <= w_edge;
            r_cen_div <= 1'b0;
            r_lost    <= 1'b0;
            if (w_edge) begin
                r_cnt <= {PW{1'b0}};
            end else begin
                r_cnt <= w_cnt_inc;
            end

            case (r_state)
                ST_UNLOCKED: begin
                    // The first edge only starts a measurement; it is not judged.
                    r_locked <= 1'b0;
                    r_good   <= {GW{1'b0}};
                    r_div    <= {DW{1'b0}};
                    if (w_edge) begin
                        r_state <= ST_ACQUIRE;
                    end else begin
                        r_state <= ST_UNLOCKED;
                    end
                end

                ST_ACQUIRE: begin
                    r_locked <= 1'b0;
                    r_div    <= {DW{1'b0}};
                    if (w_edge) begin
                        if (w_in_win) begin
                            if (r_good == GOOD_LAST) begin
                                r_state  <= ST_LOCKED;
                                r_locked <= 1'b1;
                                r_good   <= {GW{1'b0}};
                            end else begin
                                r_good <= r_good + GW'(1);
                            end
                        end else begin
                            r_good <= {GW{1'b0}};
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_UNLOCKED;
                        r_good  <= {GW{1'b0}};
                    end else begin
                        r_state <= ST_ACQUIRE;
                    end
                end

                ST_LOCKED: begin
                    if ((w_edge && !w_in_win) || w_timeout) begin
                        r_state  <= ST_UNLOCKED;
                        r_locked <= 1'b0;
                        r_lost   <= 1'b1;
                        r_div    <= {DW{1'b0}};
                    end else if (w_edge) begin
                        // Good edge while locked: advance the divider.
                        r_locked <= 1'b1;
                        if (r_div == DIV_LAST) begin
                            r_div     <= {DW{1'b0}};
                            r_cen_div <= 1'b1;
                        end else begin
                            r_div <= r_div + DW'(1);
                        end
                    end else begin
                        r_locked <= 1'b1;
                        r_state  <= ST_LOCKED;
                    end
                end

                default: begin
                    r_state  <= ST_UNLOCKED;
                    r_locked <= 1'b0;
                    r_good   <= {GW{1'b0}};
                    r_div    <= {DW{1'b0}};
                end
            endcase
        end
    end

    assign cen     = r_cen;
    assign cen_div = r_cen_div;
    assign locked  = r_locked;
    assign lost    = r_lost;

`ifdef CEN_GEN_PERIOD_OUT_EN
    logic [PW-1:0] r_period;

    // Capture the measured period on the same cycle cen is issued
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            r_period <= {PW{1'b0}};
        end else if (w_edge) begin
            r_period <= w_cnt_inc;
        end else begin
            r_period <= r_period;
        end
    end

    assign period = r_period;
`endif

endmodule

// File: tb/tb_cen_generator.sv
// -----------------------------------------------------------------------------
// tb_cen_generator
//
// Directed bench for cen_generator. clk_slow is driven from the bench on
// falling edges of clk_100mhz with an exact period in clk_100mhz cycles. A
// monitor samples the DUT 1 ns after every rising edge and records pulse
// counts and the cycle numbers at which pulses and lock changes appear.
// -----------------------------------------------------------------------------
module tb_cen_generator;

    logic clk_100mhz = 1'b0;
    logic reset      = 1'b1;
    logic clk_slow   = 1'b0;
    logic cen;
    logic cen_div;
    logic locked;
    logic lost;
`ifdef CEN_GEN_PERIOD_OUT_EN
    logic [7:0] period;
`endif

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int cen_cnt = 0;
    int div_cnt = 0;
    int lost_cnt = 0;
    int dbl_cen = 0;
    int dbl_div = 0;
    int dbl_lost = 0;
    int div_no_cen = 0;
    int last_cen_cyc = -1;
    int last_div_cyc = -1;
    int last_lost_cyc = -1;
    int lock_rise_cyc = -1;
    int lock_fall_cyc = -1;
    int rise_cyc = 0;

    cen_generator dut (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .clk_slow   (clk_slow),
        .cen        (cen),
        .cen_div    (cen_div),
        .locked     (locked),
        .lost       (lost)
`ifdef CEN_GEN_PERIOD_OUT_EN
        ,
        .period     (period)
`endif
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Output monitor: sampled 1 ns after each rising edge
    initial begin
        logic p_cen, p_div, p_lost, p_locked;
        p_cen = 1'b0; p_div = 1'b0; p_lost = 1'b0; p_locked = 1'b0;
        forever begin
            @(posedge clk_100mhz);
            #1;
            cyc++;
            if (cen === 1'b1) begin cen_cnt++; last_cen_cyc = cyc; end
            if (cen === 1'b1 && p_cen) dbl_cen++;
            if (cen_div === 1'b1) begin div_cnt++; last_div_cyc = cyc; end
            if (cen_div === 1'b1 && cen !== 1'b1) div_no_cen++;
            if (cen_div === 1'b1 && p_div) dbl_div++;
            if (lost === 1'b1) begin lost_cnt++; last_lost_cyc = cyc; end
            if (lost === 1'b1 && p_lost) dbl_lost++;
            if (locked === 1'b1 && !p_locked) lock_rise_cyc = cyc;
            if (locked !== 1'b1 && p_locked) lock_fall_cyc = cyc;
            p_cen = (cen === 1'b1);
            p_div = (cen_div === 1'b1);
            p_lost = (lost === 1'b1);
            p_locked = (locked === 1'b1);
        end
    end

    // One clk_slow period of p cycles, starting with the rising edge.
    task automatic drive_period(input int p);
        clk_slow = 1'b1;
        rise_cyc = cyc;
        repeat (p / 2) @(negedge clk_100mhz);
        clk_slow = 1'b0;
        repeat (p - p / 2) @(negedge clk_100mhz);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk_100mhz);
        for (int i = 0; i < 3; i++) drive_period(4);
        checks++;
        if ({cen, cen_div, locked, lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0000", {cen, cen_div, locked, lost});
        end
        checks++;
        if (cen_cnt !== 0) begin
            errors++;
            $display("FAIL reset_no_cen: got %0d cens expected 0", cen_cnt);
        end
`ifdef CEN_GEN_PERIOD_OUT_EN
        checks++;
        if (period !== 8'd0) begin
            errors++;
            $display("FAIL reset_period: got %0d expected 0", period);
        end
`endif
        reset = 1'b0;
        repeat (5) @(negedge clk_100mhz);
        checks++;
        if (cen_cnt !== 0) begin
            errors++;
            $display("FAIL release_no_cen: got %0d cens expected 0", cen_cnt);
        end
    endtask

    task automatic test_acquire();
        for (int k = 1; k <= 5; k++) begin
            drive_period(50);
            checks++;
            if (cen_cnt !== k) begin
                errors++;
                $display("FAIL acq_cen_count[%0d]: got %0d expected %0d", k, cen_cnt, k);
            end
            checks++;
            if (last_cen_cyc !== rise_cyc + 3) begin
                errors++;
                $display("FAIL acq_latency[%0d]: got %0d expected %0d", k, last_cen_cyc - rise_cyc, 3);
            end
            checks++;
            if (locked !== (k == 5)) begin
                errors++;
                $display("FAIL acq_locked[%0d]: got %b expected %b", k, locked, (k == 5));
            end
        end
        checks++;
        if (lock_rise_cyc !== last_cen_cyc) begin
            errors++;
            $display("FAIL lock_with_cen: got %0d expected %0d", lock_rise_cyc, last_cen_cyc);
        end
`ifdef CEN_GEN_PERIOD_OUT_EN
        checks++;
        if (period !== 8'd50) begin
            errors++;
            $display("FAIL period_value: got %0d expected 50", period);
        end
`endif
    endtask

    task automatic test_cen_div();
        for (int k = 1; k <= 12; k++) begin
            drive_period(50);
            if (k == 5 || k == 6 || k == 11 || k == 12) begin
                checks++;
                if (div_cnt !== k / 6) begin
                    errors++;
                    $display("FAIL div_count[%0d]: got %0d expected %0d", k, div_cnt, k / 6);
                end
            end
            if (k == 6 || k == 12) begin
                checks++;
                if (last_div_cyc !== last_cen_cyc) begin
                    errors++;
                    $display("FAIL div_with_cen[%0d]: got %0d expected %0d", k, last_div_cyc, last_cen_cyc);
                end
            end
        end
        checks++;
        if (dbl_div + div_no_cen + dbl_cen !== 0) begin
            errors++;
            $display("FAIL pulse_width: got %0d bad pulses expected 0", dbl_div + div_no_cen + dbl_cen);
        end
    endtask

    task automatic test_bad_period();
        drive_period(60);
        drive_period(50);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL bad_unlock: got %b expected 0", locked);
        end
        checks++;
        if (lost_cnt !== 1 || last_lost_cyc !== last_cen_cyc) begin
            errors++;
            $display("FAIL bad_lost: got %0d pulses at %0d expected 1 at %0d", lost_cnt, last_lost_cyc, last_cen_cyc);
        end
        checks++;
        if (div_cnt !== 2) begin
            errors++;
            $display("FAIL bad_no_div: got %0d expected 2", div_cnt);
        end
        for (int k = 0; k < 4; k++) drive_period(50);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: got %b expected 0", locked);
        end
        drive_period(50);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL relock: got %b expected 1", locked);
        end
    endtask

    task automatic test_timeout();
        int edge_cyc;
        edge_cyc = last_cen_cyc;
        for (int i = 0; i < 300 && locked === 1'b1; i++) @(negedge clk_100mhz);
        checks++;
        if (locked !== 1'b0 || lock_fall_cyc !== edge_cyc + 200) begin
            errors++;
            $display("FAIL timeout_unlock: got locked=%b after %0d expected 0 after 200", locked, lock_fall_cyc - edge_cyc);
        end
        checks++;
        if (lost_cnt !== 2 || last_lost_cyc !== edge_cyc + 200 || dbl_lost !== 0) begin
            errors++;
            $display("FAIL timeout_lost: got %0d pulses at +%0d expected 2 at +200", lost_cnt, last_lost_cyc - edge_cyc);
        end
        checks++;
        if (div_cnt !== 2) begin
            errors++;
            $display("FAIL timeout_no_div: got %0d expected 2", div_cnt);
        end
    endtask

    task automatic test_window();
        int c0;
        // 48 and 52 are inside the window
        drive_period(48);
        drive_period(52);
        drive_period(48);
        drive_period(52);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL win_early: got %b expected 0", locked);
        end
        drive_period(50);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL win_edges_ok: got %b expected 1", locked);
        end
        // 47 drops lock
        drive_period(47);
        drive_period(50);
        checks++;
        if (locked !== 1'b0 || lost_cnt !== 3) begin
            errors++;
            $display("FAIL win_47: got locked=%b lost=%0d expected 0 and 3", locked, lost_cnt);
        end
        // 53 clears the good count during acquisition
        drive_period(50);
        drive_period(50);
        drive_period(50);
        drive_period(53);
        drive_period(50);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL win_53: got %b expected 0", locked);
        end
        for (int k = 0; k < 3; k++) drive_period(50);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL win_53_count: got %b expected 0", locked);
        end
        // Reset in the middle of acquisition (good count is 3 here)
        reset = 1'b1;
        #1;
        checks++;
        if ({cen, cen_div, locked, lost} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: got %b expected 0000", {cen, cen_div, locked, lost});
        end
        repeat (4) @(negedge clk_100mhz);
        reset = 1'b0;
        c0 = cen_cnt;
        repeat (3) @(negedge clk_100mhz);
        checks++;
        if (cen_cnt !== c0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset_clear: got cens=%0d locked=%b expected %0d and 0", cen_cnt, locked, c0);
        end
        for (int k = 0; k < 4; k++) drive_period(50);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reacq: got %b expected 0", locked);
        end
        drive_period(50);
        checks++;
        if (locked !== 1'b1) begin
            errors++;
            $display("FAIL midreset_lock: got %b expected 1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_cen_div();
        test_bad_period();
        test_timeout();
        test_window();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
